decoder_scan: RTL and testbench
===============================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter N, default 4: select width; output width is 2**N (N = 1..6).
REQ-002 Parameter DIV, default 4: enabled clock cycles per scan step (DIV >= 1).
REQ-003 Parameter ACTIVE_LOW, default 0: 1 inverts every bit of y (selected line 0, others 1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 en  input  1  enable; 0 deasserts all outputs and freezes scan state.
REQ-007 mode  input  1  0 = DIRECT (decode s), 1 = SCAN (auto-step through lines).
REQ-008 s  input  N  select in DIRECT; start index when entering SCAN.
REQ-009 y  output  2**N  registered one-hot (or one-cold) decoded output.
REQ-010 idx  output  N  registered index currently driven on y.
REQ-011 wrap  output  1  one-cycle pulse when SCAN index wraps from 2**N-1 to 0.

Function
REQ-012 Block SHALL be a two-state FSM: DIRECT, SCAN; state follows mode, sampled each rising edge.
REQ-013 "Inactive" y SHALL mean all 0 when ACTIVE_LOW=0, all 1 when ACTIVE_LOW=1.
REQ-014 DIRECT, en=1: next edge SHALL load idx <= s and drive y with only bit s active (1-cycle latency).
REQ-015 DIRECT SHALL hold prescaler at 0 and wrap at 0.
REQ-016 Transition DIRECT->SCAN (mode 0->1): on that edge idx <= s, prescaler <= 0, y selects bit s if en=1.
REQ-017 SCAN, en=1: prescaler SHALL count 0..DIV-1; on the edge where prescaler = DIV-1, prescaler <= 0 and idx <= idx+1 modulo 2**N.
REQ-018 DIV=1 SHALL advance idx every enabled cycle.
REQ-019 On the edge where idx moves 2**N-1 -> 0, wrap SHALL be 1 for exactly the following cycle; otherwise 0.
REQ-020 y SHALL always equal decode(idx) while en=1, registered with idx on the same edge.
REQ-021 en=0 (either mode): next edge y <= inactive, wrap <= 0; idx and prescaler hold.
REQ-022 en 0->1 in SCAN: scanning SHALL resume from held idx and prescaler, no re-load from s.
REQ-023 Transition SCAN->DIRECT: next edge behaves per REQ-014/015; prescaler cleared.
REQ-024 Simultaneous mode 0->1 and en=0: state SHALL become SCAN with idx <= s, prescaler 0, y inactive.
REQ-025 s changes in SCAN SHALL be ignored.
REQ-026 Exactly one bit of y SHALL be active whenever en was 1 at the prior edge and rst_n high.

Reset
REQ-027 rst_n low SHALL immediately, regardless of clk: state DIRECT, idx 0, prescaler 0, wrap 0, y inactive.
REQ-028 Reset asserted mid-scan SHALL discard progress; after release, first edge follows mode/en/s as from DIRECT.
REQ-029 While rst_n low, outputs SHALL hold reset values through clock edges.

Verification (N=4, DIV=4, ACTIVE_LOW=0 unless stated)
REQ-030 DIRECT, en=1, s=4,0,15 each 2 cycles -> y=0x0010, 0x0001, 0x8000 one edge after each s; idx matches.
REQ-031 DIRECT, en=0, s=4 -> y=0x0000, idx holds previous value.
REQ-032 mode 0->1 with s=14, en=1 -> idx 14 for 4 cycles, 15 for 4, then 0 with wrap=1 for one cycle, y=0x0001.
REQ-033 SCAN, idx=5 mid-step, en=0 for 3 cycles then 1 -> y=0 while low; idx 5 resumes, advances after remaining prescaler count.
REQ-034 rst_n pulsed low between clock edges during SCAN -> y=0, idx=0, wrap=0 immediately; DIRECT after release.
REQ-035 ACTIVE_LOW=1, DIV=1, SCAN from s=0 -> y=0xFFFE, 0xFFFD, ... advancing every cycle; wrap after 16 cycles.

Source files
------------

// File: rtl/decoder_scan_if.sv
// Decoder/scan bus: controller drives en/mode/s, decoder returns registered y/idx/wrap.
interface decoder_scan_if #(
  parameter int N = 4
);
  logic             en;
  logic             mode;
  logic [N-1:0]     s;
  logic [2**N-1:0]  y;
  logic [N-1:0]     idx;
  logic             wrap;

  modport master (
    output en, mode, s,
    input  y, idx, wrap
  );

  modport slave (
    input  en, mode, s,
    output y, idx, wrap
  );
endinterface

// File: rtl/decoder_scan.sv
// N-to-2**N decoder with DIRECT (decode s) and SCAN (auto-step every DIV enabled cycles) modes.
// Outputs registered, 1-cycle latency; no backpressure, en=0 blanks y and freezes scan state.
module decoder_scan #(
  parameter int N          = 4,
  parameter int DIV        = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_scan_if.slave  bus
);
  localparam int W  = 2**N;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [W-1:0]  INACTIVE   = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [W-1:0]  LSB_ONE    = W'(1);
  localparam logic [N-1:0]  IDX_ONE    = N'(1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic {
    ST_DIRECT = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;

  function automatic logic [W-1:0] decode(input logic [N-1:0] i);
    return (LSB_ONE << i) ^ INACTIVE;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_DIRECT;
      presc    <= '0;
      bus.idx  <= '0;
      bus.y    <= INACTIVE;
      bus.wrap <= 1'b0;
    end else begin
      bus.wrap <= 1'b0;
      if (!bus.mode) begin
        state <= ST_DIRECT;
        presc <= '0;
        if (bus.en) begin
          bus.idx <= bus.s;
          bus.y   <= decode(bus.s);
        end else begin
          bus.y   <= INACTIVE;
        end
      end else if (state == ST_DIRECT) begin
        // Entering SCAN always latches the start index, even while disabled.
        state   <= ST_SCAN;
        presc   <= '0;
        bus.idx <= bus.s;
        bus.y   <= bus.en ? decode(bus.s) : INACTIVE;
      end else if (bus.en) begin
        if (presc == PRESC_LAST) begin
          presc    <= '0;
          bus.idx  <= bus.idx + IDX_ONE;
          bus.y    <= decode(bus.idx + IDX_ONE);
          bus.wrap <= &bus.idx;
        end else begin
          presc    <= presc + PRESC_ONE;
          bus.y    <= decode(bus.idx);
        end
      end else begin
        bus.y <= INACTIVE;
      end
    end
  end
endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench: table of single-edge vectors plus hand sequences for scan timing, reset and active-low.
module tb_decoder_scan;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  decoder_scan_if #(.N(4)) bus_a ();
  decoder_scan_if #(.N(4)) bus_b ();

  decoder_scan #(.N(4), .DIV(4), .ACTIVE_LOW(0)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  decoder_scan #(.N(4), .DIV(1), .ACTIVE_LOW(1)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        en;
    logic        mode;
    logic [3:0]  s;
    logic [15:0] y;
    logic [3:0]  idx;
    logic        wrap;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_a(input string nm, input logic [15:0] ey, input logic [3:0] ei, input logic ew);
    chk({nm, ".y"},    32'(bus_a.y),    32'(ey));
    chk({nm, ".idx"},  32'(bus_a.idx),  32'(ei));
    chk({nm, ".wrap"}, 32'(bus_a.wrap), 32'(ew));
  endtask

  initial begin
    logic [3:0]  ei;
    logic [15:0] ey;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_a.en = 1'b0; bus_a.mode = 1'b0; bus_a.s = 4'd0;
    bus_b.en = 1'b0; bus_b.mode = 1'b0; bus_b.s = 4'd0;

    //          en    mode  s      y          idx    wrap
    vecs[0]  = '{1'b1, 1'b0, 4'd4,  16'h0010, 4'd4,  1'b0};
    vecs[1]  = '{1'b1, 1'b0, 4'd4,  16'h0010, 4'd4,  1'b0};
    vecs[2]  = '{1'b1, 1'b0, 4'd0,  16'h0001, 4'd0,  1'b0};
    vecs[3]  = '{1'b1, 1'b0, 4'd0,  16'h0001, 4'd0,  1'b0};
    vecs[4]  = '{1'b1, 1'b0, 4'd15, 16'h8000, 4'd15, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'd15, 16'h8000, 4'd15, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'd4,  16'h0000, 4'd15, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 4'd7,  16'h0080, 4'd7,  1'b0};
    // Enter SCAN while disabled: start index still latched, y blank.
    vecs[8]  = '{1'b0, 1'b1, 4'd3,  16'h0000, 4'd3,  1'b0};
    // Enable in SCAN: resumes from index 3, s ignored, prescaler 0 -> 1 -> 2 -> 3 -> step.
    vecs[9]  = '{1'b1, 1'b1, 4'd9,  16'h0008, 4'd3,  1'b0};
    vecs[10] = '{1'b1, 1'b1, 4'd9,  16'h0008, 4'd3,  1'b0};
    vecs[11] = '{1'b1, 1'b1, 4'd1,  16'h0008, 4'd3,  1'b0};
    vecs[12] = '{1'b1, 1'b1, 4'd1,  16'h0010, 4'd4,  1'b0};
    vecs[13] = '{1'b1, 1'b1, 4'd1,  16'h0010, 4'd4,  1'b0};
    // Back to DIRECT.
    vecs[14] = '{1'b1, 1'b0, 4'd2,  16'h0004, 4'd2,  1'b0};
    vecs[15] = '{1'b1, 1'b0, 4'd11, 16'h0800, 4'd11, 1'b0};

    // Reset values held through clock edges.
    repeat (2) tick();
    chk_a("reset", 16'h0000, 4'd0, 1'b0);
    chk("reset.b.y", 32'(bus_b.y), 32'h0000_FFFF);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      bus_a.en   = vecs[i].en;
      bus_a.mode = vecs[i].mode;
      bus_a.s    = vecs[i].s;
      tick();
      chk_a($sformatf("vec%0d", i), vecs[i].y, vecs[i].idx, vecs[i].wrap);
    end

    // Scan from 14 through the wrap, with s scrambled after entry.
    bus_a.en = 1'b1; bus_a.mode = 1'b1; bus_a.s = 4'd14;
    for (int k = 0; k < 10; k++) begin
      tick();
      ei = 4'((14 + k / 4) % 16);
      ey = 16'h0001 << ei;
      chk_a($sformatf("scan14.k%0d", k), ey, ei, (k == 8));
      bus_a.s = 4'($urandom_range(0, 15));
    end

    // Pause mid-step at index 5 (prescaler 1), then resume.
    bus_a.mode = 1'b0; bus_a.s = 4'd0;
    tick();
    bus_a.mode = 1'b1; bus_a.s = 4'd5;
    tick();
    tick();
    chk_a("pause.pre", 16'h0020, 4'd5, 1'b0);
    bus_a.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_a($sformatf("pause.off%0d", k), 16'h0000, 4'd5, 1'b0);
    end
    bus_a.en = 1'b1;
    tick();
    chk_a("pause.on0", 16'h0020, 4'd5, 1'b0);
    tick();
    chk_a("pause.on1", 16'h0020, 4'd5, 1'b0);
    tick();
    chk_a("pause.on2", 16'h0040, 4'd6, 1'b0);

    // Asynchronous reset between edges while scanning.
    #2 rst_n = 1'b0;
    #1;
    chk_a("arst.now", 16'h0000, 4'd0, 1'b0);
    tick();
    chk_a("arst.held", 16'h0000, 4'd0, 1'b0);
    #2 rst_n = 1'b1;
    bus_a.mode = 1'b1; bus_a.s = 4'd9;
    tick();
    chk_a("arst.entry", 16'h0200, 4'd9, 1'b0);
    repeat (3) tick();
    chk_a("arst.hold", 16'h0200, 4'd9, 1'b0);
    tick();
    chk_a("arst.step", 16'h0400, 4'd10, 1'b0);

    // Active-low decoder with DIV=1 advances every cycle.
    bus_b.en = 1'b1; bus_b.mode = 1'b0; bus_b.s = 4'd0;
    tick();
    chk("al.direct.y", 32'(bus_b.y), 32'h0000_FFFE);
    bus_b.mode = 1'b1;
    for (int k = 0; k < 18; k++) begin
      tick();
      ei = 4'(k % 16);
      ey = ~(16'h0001 << ei);
      chk($sformatf("al.k%0d.y", k),    32'(bus_b.y),    32'(ey));
      chk($sformatf("al.k%0d.idx", k),  32'(bus_b.idx),  32'(ei));
      chk($sformatf("al.k%0d.wrap", k), 32'(bus_b.wrap), (k == 16) ? 32'd1 : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
